dice_game_sequencer: RTL and testbench

- Top-level sequencer for the dice game.
- Generates two pseudo-random dice from free-running counters and sequences rolls from a single roll-request pulse.
- Latches the dice, tracks roll number (`turn`) and the point, resolves win/lose, and keeps saturating win/loss tallies for display.
- Sits between the debounced push-button logic and the seven-segment/LED display drivers.

---
 rtl/dice_pkg.sv | 30 +++
 rtl/dice_spinner.sv | 31 +++
 rtl/dice_game_sequencer.sv | 170 +++++++++++++++++
 tb/tb_dice_game_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared types and constants for the dice game sequencer: state encoding,
// die width, winning sums and small die-arithmetic helpers.
package dice_pkg;

  localparam int DIE_W = 4;

  localparam logic [DIE_W-1:0] DIE_MIN   = 4'd1;
  localparam logic [DIE_W-1:0] DIE_MAX   = 4'd6;
  localparam logic [DIE_W-1:0] WIN_SUM_A = 4'd5;
  localparam logic [DIE_W-1:0] WIN_SUM_B = 4'd11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SPIN = 3'd1,
    EVAL = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_e;

  // Next face of a free-running die, 1..6 then back to 1.
  function automatic logic [DIE_W-1:0] die_next(input logic [DIE_W-1:0] v);
    return (v == DIE_MAX) ? DIE_MIN : v + 4'd1;
  endfunction

  // Sums that decide a game immediately (win on roll 1, lose afterwards).
  function automatic logic is_natural(input logic [DIE_W-1:0] s);
    return (s == WIN_SUM_A) || (s == WIN_SUM_B);
  endfunction

endpackage

// File: rtl/dice_spinner.sv
// Two cascaded free-running 1..6 counters; die 2 advances only when die 1
// wraps, so the pair walks through all 36 combinations.
module dice_spinner
  import dice_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic [DIE_W-1:0] d1c,
  output logic [DIE_W-1:0] d2c
);

  logic [DIE_W-1:0] d1c_q;
  logic [DIE_W-1:0] d2c_q;

  // Cascaded face counters, running in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1c_q <= DIE_MIN;
      d2c_q <= DIE_MIN;
    end else begin
      d1c_q <= die_next(d1c_q);
      if (d1c_q == DIE_MAX) begin
        d2c_q <= die_next(d2c_q);
      end
    end
  end

  assign d1c = d1c_q;
  assign d2c = d2c_q;

endmodule

// File: rtl/dice_game_sequencer.sv
// Dice game sequencer: spins the dice on a roll request, latches them,
// resolves win/lose against the point and keeps saturating tallies.
module dice_game_sequencer
  import dice_pkg::*;
#(
  parameter int SPIN_CYCLES = 8,
  parameter int MAX_ROLLS   = 2,
  parameter int TALLY_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               roll_req,
  input  logic               force_en,
  input  logic [DIE_W-1:0]   force_d1,
  input  logic [DIE_W-1:0]   force_d2,
  output logic [DIE_W-1:0]   die1,
  output logic [DIE_W-1:0]   die2,
  output logic [DIE_W-1:0]   sum,
  output logic [DIE_W-1:0]   point,
  output logic [1:0]         turn,
  output logic               busy,
  output logic               win,
  output logic               lose,
  output logic [TALLY_W-1:0] wins,
  output logic [TALLY_W-1:0] losses
);

  localparam logic [7:0]         SPIN_LAST = 8'(SPIN_CYCLES - 1);
  localparam logic [1:0]         TURN_LAST = 2'(MAX_ROLLS);
  localparam logic [TALLY_W-1:0] TALLY_ONE = {{(TALLY_W-1){1'b0}}, 1'b1};

  logic [DIE_W-1:0] d1c;
  logic [DIE_W-1:0] d2c;

  state_e           state_q;
  logic [7:0]       spin_cnt_q;
  logic [DIE_W-1:0] die1_q;
  logic [DIE_W-1:0] die2_q;
  logic [DIE_W-1:0] sum_q;
  logic [DIE_W-1:0] point_q;
  logic [1:0]       turn_q;
  logic             busy_q;
  logic             win_q;
  logic             lose_q;
  logic [TALLY_W-1:0] wins_q;
  logic [TALLY_W-1:0] losses_q;

  logic [DIE_W-1:0] latch_d1_d;
  logic [DIE_W-1:0] latch_d2_d;
  logic [DIE_W-1:0] latch_sum_d;
  logic [TALLY_W-1:0] wins_d;
  logic [TALLY_W-1:0] losses_d;

  dice_spinner u_spin (
    .clk (clk),
    .rst (rst),
    .d1c (d1c),
    .d2c (d2c)
  );

  // Die source select and saturating tally increments.
  always_comb begin
    latch_d1_d  = force_en ? force_d1 : d1c;
    latch_d2_d  = force_en ? force_d2 : d2c;
    latch_sum_d = latch_d1_d + latch_d2_d;
    if (wins_q == {TALLY_W{1'b1}}) begin
      wins_d = wins_q;
    end else begin
      wins_d = wins_q + TALLY_ONE;
    end
    if (losses_q == {TALLY_W{1'b1}}) begin
      losses_d = losses_q;
    end else begin
      losses_d = losses_q + TALLY_ONE;
    end
  end

  // Game FSM with registered outputs; DONE restarts a game directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      spin_cnt_q <= 8'd0;
      die1_q     <= 4'd0;
      die2_q     <= 4'd0;
      sum_q      <= 4'd0;
      point_q    <= 4'd0;
      turn_q     <= 2'd0;
      busy_q     <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      wins_q     <= '0;
      losses_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (roll_req) begin
            state_q    <= SPIN;
            spin_cnt_q <= 8'd0;
            turn_q     <= 2'd1;
            point_q    <= 4'd0;
            busy_q     <= 1'b1;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
          end
        end
        SPIN: begin
          if (spin_cnt_q == SPIN_LAST) begin
            die1_q  <= latch_d1_d;
            die2_q  <= latch_d2_d;
            sum_q   <= latch_sum_d;
            state_q <= EVAL;
          end else begin
            spin_cnt_q <= spin_cnt_q + 8'd1;
          end
        end
        EVAL: begin
          busy_q <= 1'b0;
          if (turn_q == 2'd1) begin
            if (is_natural(sum_q)) begin
              win_q   <= 1'b1;
              wins_q  <= wins_d;
              state_q <= DONE;
            end else begin
              point_q <= sum_q;
              state_q <= WAIT;
            end
          end else if (is_natural(sum_q)) begin
            lose_q   <= 1'b1;
            losses_q <= losses_d;
            state_q  <= DONE;
          end else if (sum_q == point_q) begin
            win_q   <= 1'b1;
            wins_q  <= wins_d;
            state_q <= DONE;
          end else if (turn_q == TURN_LAST) begin
            lose_q   <= 1'b1;
            losses_q <= losses_d;
            state_q  <= DONE;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (roll_req) begin
            state_q    <= SPIN;
            spin_cnt_q <= 8'd0;
            turn_q     <= turn_q + 2'd1;
            busy_q     <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign die1   = die1_q;
  assign die2   = die2_q;
  assign sum    = sum_q;
  assign point  = point_q;
  assign turn   = turn_q;
  assign busy   = busy_q;
  assign win    = win_q;
  assign lose   = lose_q;
  assign wins   = wins_q;
  assign losses = losses_q;

endmodule

// File: tb/tb_dice_game_sequencer.sv
// Self-checking bench for dice_game_sequencer: directed games, reset and
// saturation cases, then randomized rolls against a game-level model.
module tb_dice_game_sequencer;

  localparam int SPIN = 8;
  localparam int MAXR = 2;
  localparam int TW   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          roll_req = 1'b0;
  logic          force_en = 1'b0;
  logic [3:0]    force_d1 = 4'd0;
  logic [3:0]    force_d2 = 4'd0;
  logic [3:0]    die1, die2, sum, point;
  logic [1:0]    turn;
  logic          busy, win, lose;
  logic [TW-1:0] wins, losses;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int unsigned cyc = 0;

  // game-level model: phase 0 = no game yet, 1 = awaiting next roll, 2 = decided
  int m_phase, m_turn, m_point, m_d1, m_d2, m_sum, m_win, m_lose, m_wins, m_losses;

  dice_game_sequencer #(
    .SPIN_CYCLES (SPIN),
    .MAX_ROLLS   (MAXR),
    .TALLY_W     (TW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .roll_req (roll_req),
    .force_en (force_en),
    .force_d1 (force_d1),
    .force_d2 (force_d2),
    .die1     (die1),
    .die2     (die2),
    .sum      (sum),
    .point    (point),
    .turn     (turn),
    .busy     (busy),
    .win      (win),
    .lose     (lose),
    .wins     (wins),
    .losses   (losses)
  );

  always #5 clk = ~clk;

  // edges since the last reset edge; the dice faces are a pure function of it
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_turn = 0; m_point = 0; m_d1 = 0; m_d2 = 0; m_sum = 0;
    m_win = 0; m_lose = 0; m_wins = 0; m_losses = 0;
  endtask

  task automatic model_start();
    if (m_phase == 1) begin
      m_turn = m_turn + 1;
    end else begin
      m_turn = 1; m_point = 0; m_win = 0; m_lose = 0;
    end
  endtask

  task automatic model_eval(input int s);
    bit natural;
    natural = (s == 5) || (s == 11);
    m_phase = 2;
    if (m_turn == 1 && natural) m_win = 1;
    else if (m_turn == 1) begin m_point = s; m_phase = 1; end
    else if (natural) m_lose = 1;
    else if (s == m_point) m_win = 1;
    else if (m_turn == MAXR) m_lose = 1;
    else m_phase = 1;
    if (m_win == 1) m_wins = (m_wins + 1 > 3) ? 3 : m_wins + 1;
    if (m_lose == 1) m_losses = (m_losses + 1 > 3) ? 3 : m_losses + 1;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".die1"}, die1, m_d1);
    chk({tag, ".die2"}, die2, m_d2);
    chk({tag, ".sum"}, sum, m_sum);
    chk({tag, ".point"}, point, m_point);
    chk({tag, ".turn"}, turn, m_turn);
    chk({tag, ".win"}, win, m_win);
    chk({tag, ".lose"}, lose, m_lose);
    chk({tag, ".wins"}, wins, m_wins);
    chk({tag, ".losses"}, losses, m_losses);
    chk({tag, ".excl"}, win & lose, 0);
  endtask

  // One roll: request held `hold` cycles, optional stray request mid-spin.
  task automatic roll(input bit fen, input int f1, input int f2, input int hold, input bit poke);
    @(negedge clk);
    roll_req = 1'b1;
    force_en = fen;
    force_d1 = 4'(f1);
    force_d2 = 4'(f2);
    model_start();
    for (int j = 0; j <= SPIN; j++) begin
      @(negedge clk);
      chk("busy_spin", busy, 1);
      if (j == 0) begin
        chk("start.turn", turn, m_turn);
        chk("start.point", point, m_point);
        chk("start.win", win, m_win);
        chk("start.lose", lose, m_lose);
      end
      if (j == SPIN) begin
        m_d1  = fen ? f1 : int'((cyc - 1) % 6 + 1);
        m_d2  = fen ? f2 : int'(((cyc - 1) / 6) % 6 + 1);
        m_sum = m_d1 + m_d2;
        chk("latch.die1", die1, m_d1);
        chk("latch.die2", die2, m_d2);
        chk("latch.sum", sum, m_sum);
      end
      roll_req = ((j + 1) < hold) || (poke && j == 3);
    end
    @(negedge clk);
    model_eval(m_sum);
    chk("busy_eval_done", busy, 0);
    chk_all("result");
    force_en = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_all("reset");
      chk("reset.busy", busy, 0);
      chk("spin.d1c", dut.u_spin.d1c, i + 1);
      chk("spin.d2c", dut.u_spin.d2c, 1);
      @(negedge clk);
    end

    roll(1'b1, 2, 3, 1, 1'b0);          // natural on roll 1
    roll(1'b1, 3, 1, 1, 1'b0);          // point 4
    roll(1'b1, 2, 2, 2, 1'b0);          // make point
    roll(1'b1, 4, 4, 1, 1'b0);          // point 8
    roll(1'b1, 5, 6, 1, 1'b1);          // 11 after roll 1 loses
    roll(1'b1, 1, 1, 1, 1'b0);          // point 2
    roll(1'b1, 6, 1, 3, 1'b0);          // roll limit reached
    roll(1'b0, 0, 0, 1, 1'b1);          // unforced from DONE

    // reset mid-spin
    @(negedge clk);
    roll_req = 1'b1;
    force_en = 1'b1; force_d1 = 4'd2; force_d2 = 4'd3;
    @(negedge clk);
    roll_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    force_en = 1'b0;
    model_reset();
    chk_all("midreset");
    chk("midreset.busy", busy, 0);
    chk("midreset.d1c", dut.u_spin.d1c, 1);

    for (int i = 0; i < 4; i++) roll(1'b1, 2, 3, 1, 1'b0);
    chk("sat.wins", wins, 3);

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = int'($urandom_range(5, 0));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("idle.busy", busy, 0);
      end
      roll(1'($urandom_range(1, 0)), int'($urandom_range(6, 1)), int'($urandom_range(6, 1)),
           int'($urandom_range(3, 1)), 1'($urandom_range(1, 0)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
